// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit and its lane aligner.
package mem_pkg;

    localparam int unsigned BYTEEN_W = 4;
    localparam int unsigned F3_W     = 3;

    localparam logic [F3_W-1:0] LB  = 3'b000;
    localparam logic [F3_W-1:0] LH  = 3'b001;
    localparam logic [F3_W-1:0] LW  = 3'b010;
    localparam logic [F3_W-1:0] LBU = 3'b100;
    localparam logic [F3_W-1:0] LHU = 3'b101;
    localparam logic [F3_W-1:0] SB  = 3'b000;
    localparam logic [F3_W-1:0] SH  = 3'b001;
    localparam logic [F3_W-1:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mau_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables/replication, load extraction and
// extension, and misalignment / unsupported-width detection.
module lsu_align
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [F3_W-1:0]     funct3,
    input  logic [1:0]          addr_lo,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [WIDTH-1:0]    rdata,
    output logic [BYTEEN_W-1:0] byteen,
    output logic [WIDTH-1:0]    wdata_shifted,
    output logic [WIDTH-1:0]    rdata_ext,
    output logic                misaligned
);

    logic [WIDTH-1:0] rdata_lane;

    assign rdata_lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        byteen        = '0;
        wdata_shifted = '0;
        rdata_ext     = '0;
        misaligned    = 1'b0;
        case (funct3)
            LB: begin
                byteen        = 4'b0001 << addr_lo;
                wdata_shifted = WIDTH'({4{wdata[7:0]}});
                rdata_ext     = {{(WIDTH-8){rdata_lane[7]}}, rdata_lane[7:0]};
            end
            LBU: begin
                byteen        = 4'b0001 << addr_lo;
                wdata_shifted = WIDTH'({4{wdata[7:0]}});
                rdata_ext     = {{(WIDTH-8){1'b0}}, rdata_lane[7:0]};
            end
            LH: begin
                byteen        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_shifted = WIDTH'({2{wdata[15:0]}});
                rdata_ext     = {{(WIDTH-16){rdata_lane[15]}}, rdata_lane[15:0]};
                misaligned    = addr_lo[0];
            end
            LHU: begin
                byteen        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_shifted = WIDTH'({2{wdata[15:0]}});
                rdata_ext     = {{(WIDTH-16){1'b0}}, rdata_lane[15:0]};
                misaligned    = addr_lo[0];
            end
            LW: begin
                byteen        = 4'b1111;
                wdata_shifted = wdata;
                rdata_ext     = rdata;
                misaligned    = |addr_lo;
            end
            // 011, 110, 111 have no RV32I load/store meaning
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Bus initiator: arbitrates fetch and load/store requests (LSU first), runs one
// aligned bus access at a time and returns a single-cycle response pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req_valid,
    output logic                fetch_req_ready,
    input  logic [WIDTH-1:0]    fetch_addr,
    output logic                fetch_resp_valid,
    output logic [WIDTH-1:0]    fetch_instr,
    output logic                fetch_fault,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [F3_W-1:0]     lsu_funct3,
    input  logic [WIDTH-1:0]    lsu_addr,
    input  logic [WIDTH-1:0]    lsu_wdata,
    output logic                lsu_resp_valid,
    output logic [WIDTH-1:0]    lsu_rdata,
    output logic                lsu_misaligned,
    output logic                mem_read,
    output logic                mem_write,
    output logic [WIDTH-1:0]    addr_out,
    output logic [WIDTH-1:0]    data_out,
    output logic [BYTEEN_W-1:0] byteen,
    input  logic [WIDTH-1:0]    mem_data_in
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    mau_state_t state_q, state_d;
    logic                src_fetch_q, src_fetch_d;
    logic                we_q, we_d;
    logic [F3_W-1:0]     funct3_q, funct3_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [WIDTH-1:0]    addr_out_q, addr_out_d;
    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic [BYTEEN_W-1:0] byteen_q, byteen_d;
    logic                fetch_resp_valid_q, fetch_resp_valid_d;
    logic [WIDTH-1:0]    fetch_instr_q, fetch_instr_d;
    logic                fetch_fault_q, fetch_fault_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [WIDTH-1:0]    lsu_rdata_q, lsu_rdata_d;
    logic                lsu_misaligned_q, lsu_misaligned_d;

    logic                idle_c;
    logic [F3_W-1:0]     al_funct3_c;
    logic [1:0]          al_addr_lo_c;
    logic [BYTEEN_W-1:0] al_byteen_c;
    logic [WIDTH-1:0]    al_wdata_c;
    logic [WIDTH-1:0]    al_rdata_c;
    logic                al_misaligned_c;

    assign idle_c          = (state_q == IDLE);
    assign lsu_req_ready   = idle_c;
    assign fetch_req_ready = idle_c && !lsu_req_valid;

    // In IDLE the aligner checks the incoming request; afterwards it extracts load data
    assign al_funct3_c  = idle_c ? lsu_funct3    : funct3_q;
    assign al_addr_lo_c = idle_c ? lsu_addr[1:0] : addr_q[1:0];

    lsu_align #(
        .WIDTH (WIDTH)
    ) u_lsu_align (
        .funct3        (al_funct3_c),
        .addr_lo       (al_addr_lo_c),
        .wdata         (lsu_wdata),
        .rdata         (mem_data_in),
        .byteen        (al_byteen_c),
        .wdata_shifted (al_wdata_c),
        .rdata_ext     (al_rdata_c),
        .misaligned    (al_misaligned_c)
    );

    // Next state and next registered outputs; outputs default to 0 every cycle
    always_comb begin
        state_d            = state_q;
        src_fetch_d        = src_fetch_q;
        we_d               = we_q;
        funct3_d           = funct3_q;
        addr_d             = addr_q;
        cnt_d              = cnt_q;
        mem_read_d         = 1'b0;
        mem_write_d        = 1'b0;
        addr_out_d         = '0;
        data_out_d         = '0;
        byteen_d           = '0;
        fetch_resp_valid_d = 1'b0;
        fetch_instr_d      = '0;
        fetch_fault_d      = 1'b0;
        lsu_resp_valid_d   = 1'b0;
        lsu_rdata_d        = '0;
        lsu_misaligned_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (lsu_req_valid) begin
                    src_fetch_d = 1'b0;
                    we_d        = lsu_we;
                    funct3_d    = lsu_funct3;
                    addr_d      = lsu_addr;
                    if (al_misaligned_c) begin
                        state_d          = RESP;
                        lsu_resp_valid_d = 1'b1;
                        lsu_misaligned_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = CNT_W'(READ_LATENCY - 1);
                        addr_out_d = lsu_addr;
                        if (lsu_we) begin
                            mem_write_d = 1'b1;
                            byteen_d    = al_byteen_c;
                            data_out_d  = al_wdata_c;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end
                end else if (fetch_req_valid) begin
                    src_fetch_d = 1'b1;
                    we_d        = 1'b0;
                    funct3_d    = LW;
                    addr_d      = fetch_addr;
                    if (|fetch_addr[1:0]) begin
                        state_d            = RESP;
                        fetch_resp_valid_d = 1'b1;
                        fetch_fault_d      = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = CNT_W'(READ_LATENCY - 1);
                        addr_out_d = fetch_addr;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d          = RESP;
                    lsu_resp_valid_d = 1'b1;
                end else if (cnt_q == '0) begin
                    // Final read cycle: mem_data_in is valid on this edge
                    state_d = RESP;
                    if (src_fetch_q) begin
                        fetch_resp_valid_d = 1'b1;
                        fetch_instr_d      = mem_data_in;
                    end else begin
                        lsu_resp_valid_d = 1'b1;
                        lsu_rdata_d      = al_rdata_c;
                    end
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    mem_read_d = 1'b1;
                    addr_out_d = addr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            src_fetch_q        <= 1'b0;
            we_q               <= 1'b0;
            funct3_q           <= '0;
            addr_q             <= '0;
            cnt_q              <= '0;
            mem_read_q         <= 1'b0;
            mem_write_q        <= 1'b0;
            addr_out_q         <= '0;
            data_out_q         <= '0;
            byteen_q           <= '0;
            fetch_resp_valid_q <= 1'b0;
            fetch_instr_q      <= '0;
            fetch_fault_q      <= 1'b0;
            lsu_resp_valid_q   <= 1'b0;
            lsu_rdata_q        <= '0;
            lsu_misaligned_q   <= 1'b0;
        end else begin
            state_q            <= state_d;
            src_fetch_q        <= src_fetch_d;
            we_q               <= we_d;
            funct3_q           <= funct3_d;
            addr_q             <= addr_d;
            cnt_q              <= cnt_d;
            mem_read_q         <= mem_read_d;
            mem_write_q        <= mem_write_d;
            addr_out_q         <= addr_out_d;
            data_out_q         <= data_out_d;
            byteen_q           <= byteen_d;
            fetch_resp_valid_q <= fetch_resp_valid_d;
            fetch_instr_q      <= fetch_instr_d;
            fetch_fault_q      <= fetch_fault_d;
            lsu_resp_valid_q   <= lsu_resp_valid_d;
            lsu_rdata_q        <= lsu_rdata_d;
            lsu_misaligned_q   <= lsu_misaligned_d;
        end
    end

    assign mem_read         = mem_read_q;
    assign mem_write        = mem_write_q;
    assign addr_out         = addr_out_q;
    assign data_out         = data_out_q;
    assign byteen           = byteen_q;
    assign fetch_resp_valid = fetch_resp_valid_q;
    assign fetch_instr      = fetch_instr_q;
    assign fetch_fault      = fetch_fault_q;
    assign lsu_resp_valid   = lsu_resp_valid_q;
    assign lsu_rdata        = lsu_rdata_q;
    assign lsu_misaligned   = lsu_misaligned_q;

endmodule
